// File: rtl/neuron_pkg.sv
// Shared neuron datapath types and constants.
// Used by the adder and the requantiser.
package neuron_pkg;
   localparam int ACC_W     = 18;
   localparam int DEF_SHIFT = 7;
   localparam int S1_W      = ACC_W + 1;

   typedef logic signed [ACC_W-1:0] acc_t;
endpackage

// File: rtl/sat_clip.sv
// Combinational signed saturation to OUT_W bits.
// Define SUM_REQUANT_RELU_EN to also clamp negatives to zero.
module sat_clip #(
   parameter int IN_W  = 19,
   parameter int OUT_W = 8
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    sat
);
   localparam logic signed [IN_W-1:0] MAXV =
      IN_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [IN_W-1:0] MINV =
      IN_W'(-(1 << (OUT_W - 1)));

   always_comb begin
      dout = din[OUT_W-1:0];
      sat  = 1'b0;
`ifdef SUM_REQUANT_RELU_EN
      // ReLU clamp is not counted as clipping
      if (din < 0) begin
         dout = '0;
      end else if (din > MAXV) begin
         dout = MAXV[OUT_W-1:0];
         sat  = 1'b1;
      end
`else
      if (din > MAXV) begin
         dout = MAXV[OUT_W-1:0];
         sat  = 1'b1;
      end else if (din < MINV) begin
         dout = MINV[OUT_W-1:0];
         sat  = 1'b1;
      end
`endif
   end
endmodule

// File: rtl/sum_requant.sv
// Two-stage round/shift/saturate requantiser for adder sums.
// Optional ReLU via SUM_REQUANT_RELU_EN (in sat_clip).
module sum_requant
   import neuron_pkg::*;
#(
   parameter int SHIFT = DEF_SHIFT,
   parameter int OUT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [16:0]      sum_in,
   input  logic                    carry_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sat_flag,
   output logic [15:0]             sat_count
);
   localparam logic signed [S1_W-1:0] RND =
      S1_W'(1) << (SHIFT - 1);

   acc_t                    acc;
   logic signed [S1_W-1:0]  biased;
   logic signed [S1_W-1:0]  rounded;
   logic signed [S1_W-1:0]  s1_val;
   logic                    s1_valid;
   logic                    advance;
   logic signed [OUT_W-1:0] clip_d;
   logic                    clip_s;

   // One extra bit keeps the rounding add from overflowing
   assign acc     = {carry_in, sum_in};
   assign biased  = {acc[ACC_W-1], acc} + RND;
   assign rounded = biased >>> SHIFT;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !rst;

   sat_clip #(
      .IN_W  (S1_W),
      .OUT_W (OUT_W)
   ) u_clip (
      .din  (s1_val),
      .dout (clip_d),
      .sat  (clip_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_val    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
         sat_count <= '0;
      end else begin
         if (advance) begin
            s1_valid  <= in_valid;
            s1_val    <= rounded;
            out_valid <= s1_valid;
            out_data  <= clip_d;
            sat_flag  <= s1_valid && clip_s;
         end
         if (out_valid && out_ready && sat_flag &&
             sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_sum_requant.sv
// Directed, table-driven and random bench for sum_requant.
// Honours SUM_REQUANT_RELU_EN when defined.
module tb_sum_requant;
   localparam int SHIFT = 7;
   localparam int OUT_W = 8;
   localparam int OMAX  = (1 << (OUT_W - 1)) - 1;
   localparam int OMIN  = -(1 << (OUT_W - 1));

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic signed [16:0] sum_in = '0;
   logic              carry_in = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [OUT_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              sat_flag;
   logic [15:0]       sat_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int d;
      bit s;
   } exp_t;
   exp_t q[$];
   int   sat_model = 0;

   typedef struct {
      int x;
      int d;
      bit s;
   } vec_t;
   vec_t tbl[12];

   sum_requant #(.SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sum_in    (sum_in),
      .carry_in  (carry_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_flag  (sat_flag),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got,
                      input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   function automatic void relu_adj(inout int d, inout bit s);
`ifdef SUM_REQUANT_RELU_EN
      if (d < 0) begin
         d = 0;
         s = 1'b0;
      end
`endif
   endfunction

   // Reference: floor division, written independently of shifts
   function automatic void model(input int x, output int d,
                                 output bit s);
      int v, div, r;
      div = 1 << SHIFT;
      v = x + div / 2;
      if (v >= 0) r = v / div;
      else        r = -((-v + div - 1) / div);
      s = 1'b0;
      d = r;
      if (r > OMAX) begin d = OMAX; s = 1'b1; end
      if (r < OMIN) begin d = OMIN; s = 1'b1; end
      relu_adj(d, s);
   endfunction

   // Monitor: scoreboard, stall stability, in_ready, sat_count
   bit prev_stall = 1'b0;
   int prev_d;
   bit prev_s;
   always @(negedge clk) begin : mon
      logic signed [17:0] a18;
      int   ax, md;
      bit   ms;
      exp_t e;
      chk("in_ready", int'(in_ready),
          int'(!rst && (!out_valid || out_ready)));
      chk("sat_count", int'(sat_count), sat_model);
      if (prev_stall) begin
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_data", int'(out_data), prev_d);
         chk("stall_sat", int'(sat_flag), int'(prev_s));
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            e = q.pop_front();
            chk("out_data", int'(out_data), e.d);
            chk("sat_flag", int'(sat_flag), int'(e.s));
         end
         if (sat_flag && sat_model < 65535) sat_model++;
      end
      if (in_valid && in_ready) begin
         a18 = {carry_in, sum_in};
         ax = a18;
         model(ax, md, ms);
         e.d = md;
         e.s = ms;
         q.push_back(e);
      end
      prev_stall = out_valid && !out_ready && !rst;
      prev_d = int'(out_data);
      prev_s = sat_flag;
      if (rst) begin
         q.delete();
         sat_model = 0;
         prev_stall = 1'b0;
      end
   end

   task automatic send(input int x);
      int n;
      logic [17:0] b;
      b = 18'(x);
      sum_in   = b[16:0];
      carry_in = b[17];
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   bit done;

   initial begin
      tbl[0]  = '{16256, 127, 1'b0};
      tbl[1]  = '{191, 1, 1'b0};
      tbl[2]  = '{192, 2, 1'b0};
      tbl[3]  = '{-192, -1, 1'b0};
      tbl[4]  = '{-64, 0, 1'b0};
      tbl[5]  = '{32768, 127, 1'b1};
      tbl[6]  = '{-16512, -128, 1'b1};
      tbl[7]  = '{64, 1, 1'b0};
      tbl[8]  = '{-65, -1, 1'b0};
      tbl[9]  = '{-1000, -8, 1'b0};
      tbl[10] = '{131071, 127, 1'b1};
      tbl[11] = '{-131072, -128, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_sat_flag", int'(sat_flag), 0);
      chk("rst_sat_count", int'(sat_count), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Isolated vectors: exact 2-cycle latency and value
      for (int i = 0; i < 12; i++) begin
         int d;
         bit s;
         d = tbl[i].d;
         s = tbl[i].s;
         relu_adj(d, s);
         send(tbl[i].x);
         chk("lat_early", int'(out_valid), 0);
         @(posedge clk);
         #1;
         chk("lat_valid", int'(out_valid), 1);
         chk("tbl_data", int'(out_data), d);
         chk("tbl_sat", int'(sat_flag), int'(s));
         @(posedge clk);
         #1;
      end
      drain();

      // Backpressure: 5 inputs, out_ready low for 4 cycles
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) send(1280 * (i + 1) - 3000);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            chk("bp_full_in_ready", int'(in_ready), 0);
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages holding valid data
      send(32768);
      send(-16512);
      chk("mid_out_valid_pre", int'(out_valid), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_out_valid", int'(out_valid), 0);
      chk("mid_sat_count", int'(sat_count), 0);
      chk("mid_in_ready", int'(in_ready), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_valid", int'(out_valid), 0);
      send(16256);
      send(192);
      drain();

      // Random inputs with random backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++)
               send(int'($urandom_range(0, 262143)) - 131072);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // sat_count must stick at all-ones
      for (int i = 0; i < 65540; i++) send(131071);
      drain();
      @(posedge clk);
      #1;
      chk("sat_count_max", int'(sat_count), 65535);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
